// File: rtl/i2s_rx_param.sv
// I2S / left-justified serial audio receiver, fully in the mck_i domain.
// Oversampled inputs feed a slot deserialiser whose samples are queued in a small output FIFO.
module i2s_rx_param #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              mck_i,
  input  logic              rst_i,
  input  logic              bck_i,
  input  logic              lrck_i,
  input  logic              data_i,
  input  logic              fmt_i,
  output logic [DATA_W-1:0] sample_o,
  output logic              chan_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overflow_o,
  output logic              frame_err_o
);
  // state     | meaning
  // WAIT_SYNC | out of reset, ignore the stream until the first lrck boundary
  // RUN       | slot-aligned; deserialise, measure slot length, push samples

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [2:0] bck_sr;
  logic [1:0] lrck_sr;
  logic [1:0] data_sr;
  logic       strobe, lrck_s, data_s;

  state_t            state, state_nxt;
  logic              lrck_prev, lrck_prev_nxt;
  logic              primed, primed_nxt;
  logic              boundary;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [6:0]        slot_len, slot_len_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              chan_cur, chan_nxt;
  logic              push_pend, push_nxt;
  logic              ferr_set;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              full, pop, wr;

  // All three lines share one synchroniser depth so data and lrck stay aligned to the bck strobe.
  always_ff @(posedge mck_i) begin
    if (rst_i) begin
      bck_sr  <= '0;
      lrck_sr <= '0;
      data_sr <= '0;
    end else begin
      bck_sr  <= {bck_sr[1:0], bck_i};
      lrck_sr <= {lrck_sr[0], lrck_i};
      data_sr <= {data_sr[0], data_i};
    end
  end

  assign strobe = bck_sr[1] & ~bck_sr[2];
  assign lrck_s = lrck_sr[1];
  assign data_s = data_sr[1];

  always_ff @(posedge mck_i) begin
    if (rst_i) begin
      state     <= WAIT_SYNC;
      lrck_prev <= 1'b0;
      primed    <= 1'b0;
      bit_cnt   <= '0;
      slot_len  <= '0;
      shift     <= '0;
      chan_cur  <= 1'b0;
      push_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      lrck_prev <= lrck_prev_nxt;
      primed    <= primed_nxt;
      bit_cnt   <= bit_cnt_nxt;
      slot_len  <= slot_len_nxt;
      shift     <= shift_nxt;
      chan_cur  <= chan_nxt;
      push_pend <= push_nxt;
    end
  end

  // The first strobe after reset only primes lrck_prev, so a stream entered mid-slot
  // cannot fake a boundary.
  always_comb begin
    state_nxt     = state;
    lrck_prev_nxt = lrck_prev;
    primed_nxt    = primed;
    boundary      = 1'b0;
    bit_cnt_nxt   = bit_cnt;
    slot_len_nxt  = slot_len;
    shift_nxt     = shift;
    chan_nxt      = chan_cur;
    push_nxt      = 1'b0;
    ferr_set      = 1'b0;
    if (strobe) begin
      lrck_prev_nxt = lrck_s;
      primed_nxt    = 1'b1;
      boundary      = primed && (lrck_s != lrck_prev);
      if (boundary) begin
        if (state == RUN)
          ferr_set = (slot_len != 7'(SLOT_W)) || (bit_cnt < BW'(DATA_W));
        state_nxt    = RUN;
        slot_len_nxt = 7'd1;
        chan_nxt     = fmt_i ? ~lrck_s : lrck_s;
        if (fmt_i) begin
          shift_nxt   = DATA_W'({shift, data_s});
          bit_cnt_nxt = BW'(1);
          push_nxt    = (DATA_W == 1);
        end else begin
          bit_cnt_nxt = '0;
        end
      end else if (state == RUN) begin
        if (slot_len != 7'd127)
          slot_len_nxt = slot_len + 7'd1;
        if (bit_cnt < BW'(DATA_W)) begin
          shift_nxt   = DATA_W'({shift, data_s});
          bit_cnt_nxt = bit_cnt + BW'(1);
          push_nxt    = (bit_cnt == BW'(DATA_W - 1));
        end
      end
    end
  end

  assign full = (count == DEPTH_C);
  assign pop  = valid_o & ready_i;
  assign wr   = push_pend & (~full | pop);

  // The shift register holds the finished word for several mck cycles, so the write
  // one cycle after capture reads it directly.
  always_ff @(posedge mck_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (wr) begin
        mem[wptr] <= {chan_cur, shift};
        wptr      <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push_pend & full & ~pop)
        overflow_o <= 1'b1;
      if (ferr_set)
        frame_err_o <= 1'b1;
    end
  end

  assign {chan_o, sample_o} = mem[rptr];
  assign valid_o = (count != '0);

endmodule

// File: tb/tb_i2s_rx_param.sv
// Scoreboard bench for i2s_rx_param: directed I2S/LJ streams, overflow, framing errors,
// mid-slot reset and a 24-bit instance.
`timescale 1ns/1ps
module tb_i2s_rx_param;
  logic mck = 1'b0, rst = 1'b1, bck = 1'b0, lrck = 1'b0, data = 1'b0, fmt = 1'b0, ready = 1'b1;
  logic [15:0] sample;
  logic        chan, valid, ovf, ferr;
  logic        rst24 = 1'b1, ready24 = 1'b1;
  logic [23:0] sample24;
  logic        chan24, valid24, ovf24, ferr24;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        chan;
    logic [31:0] word;
  } exp_t;
  exp_t q16[$];
  exp_t q24[$];

  always #5 mck = ~mck;

  i2s_rx_param #(.DATA_W(16), .SLOT_W(32), .FIFO_DEPTH(4)) dut (
    .mck_i(mck), .rst_i(rst), .bck_i(bck), .lrck_i(lrck), .data_i(data), .fmt_i(fmt),
    .sample_o(sample), .chan_o(chan), .valid_o(valid), .ready_i(ready),
    .overflow_o(ovf), .frame_err_o(ferr));

  i2s_rx_param #(.DATA_W(24), .SLOT_W(32), .FIFO_DEPTH(4)) dut24 (
    .mck_i(mck), .rst_i(rst24), .bck_i(bck), .lrck_i(lrck), .data_i(data), .fmt_i(fmt),
    .sample_o(sample24), .chan_o(chan24), .valid_o(valid24), .ready_i(ready24),
    .overflow_o(ovf24), .frame_err_o(ferr24));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect16(input logic c, input logic [31:0] w);
    exp_t e;
    e.chan = c;
    e.word = w;
    q16.push_back(e);
  endtask

  task automatic expect24(input logic c, input logic [31:0] w);
    exp_t e;
    e.chan = c;
    e.word = w;
    q24.push_back(e);
  endtask

  // Monitors: the head is consumed on the rising edge after valid & ready.
  always @(negedge mck) begin
    exp_t e;
    if (!rst && valid && ready) begin
      if (q16.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected16: got chan %0d word %0h, required no output", chan, sample);
      end else begin
        e = q16.pop_front();
        chk("sample16", {16'h0, sample}, e.word);
        chk("chan16", {31'h0, chan}, {31'h0, e.chan});
      end
    end
  end

  always @(negedge mck) begin
    exp_t e;
    if (!rst24 && valid24 && ready24) begin
      if (q24.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected24: got chan %0d word %0h, required no output", chan24, sample24);
      end else begin
        e = q24.pop_front();
        chk("sample24", {8'h0, sample24}, e.word);
        chk("chan24", {31'h0, chan24}, {31'h0, e.chan});
      end
    end
  end

  task automatic bit_out(input logic lr, input logic d);
    bck = 1'b0; lrck = lr; data = d;
    #20;
    bck = 1'b1;
    #20;
  endtask

  // dly = 1 gives I2S placement (MSB one bck after the lrck change), 0 gives LJ.
  task automatic slot(input logic lr, input logic [31:0] w, input int width, input int len,
                      input int dly);
    int idx;
    for (int i = 0; i < len; i++) begin
      idx = i - dly;
      bit_out(lr, (idx >= 0 && idx < width) ? w[width-1-idx] : 1'b0);
    end
  endtask

  task automatic preamble(input logic lr);
    for (int i = 0; i < 4; i++) bit_out(lr, 1'b0);
  endtask

  task automatic reset16();
    bck = 1'b0;
    repeat (3) @(posedge mck);
    #1 rst = 1'b1;
    repeat (2) @(posedge mck);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q16.size() != 0 || q24.size() != 0) && n < 3000) begin
      @(posedge mck);
      n++;
    end
    repeat (3) @(posedge mck);
    #1;
    tests++;
    if (q16.size() != 0 || q24.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: %0d outputs still pending, required 0", name,
               q16.size() + q24.size());
      q16.delete();
      q24.delete();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge mck);
    #1 rst = 1'b0;
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_sample", {16'h0, sample}, 32'h0);
    chk("rst_chan", {31'h0, chan}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_ferr", {31'h0, ferr}, 32'h0);

    // I2S, 16-bit words in 32-bck slots
    fmt = 1'b0;
    preamble(1'b1);
    expect16(1'b0, 32'hA5C3); slot(1'b0, 32'hA5C3, 16, 32, 1);
    expect16(1'b1, 32'h5A3C); slot(1'b1, 32'h5A3C, 16, 32, 1);
    drain("i2s");
    chk("i2s_ovf", {31'h0, ovf}, 32'h0);
    chk("i2s_ferr", {31'h0, ferr}, 32'h0);

    // Left-justified: lrck high = left, MSB on the change
    reset16();
    fmt = 1'b1;
    preamble(1'b0);
    expect16(1'b0, 32'hA5C3); slot(1'b1, 32'hA5C3, 16, 32, 0);
    expect16(1'b1, 32'h5A3C); slot(1'b0, 32'h5A3C, 16, 32, 0);
    drain("lj");
    chk("lj_ferr", {31'h0, ferr}, 32'h0);

    // LJ stream decoded as I2S: MSB skipped, channel polarity inverted
    reset16();
    fmt = 1'b0;
    preamble(1'b0);
    expect16(1'b1, 32'h4B86); slot(1'b1, 32'hA5C3, 16, 32, 0);
    expect16(1'b0, 32'hB478); slot(1'b0, 32'h5A3C, 16, 32, 0);
    drain("mixfmt");

    // Overflow: consumer stalled for three frames
    reset16();
    #1 ready = 1'b0;
    preamble(1'b1);
    expect16(1'b0, 32'h1111); slot(1'b0, 32'h1111, 16, 32, 1);
    expect16(1'b1, 32'h2222); slot(1'b1, 32'h2222, 16, 32, 1);
    expect16(1'b0, 32'h3333); slot(1'b0, 32'h3333, 16, 32, 1);
    expect16(1'b1, 32'h4444); slot(1'b1, 32'h4444, 16, 32, 1);
    repeat (4) @(posedge mck);
    #1;
    chk("ovf_before", {31'h0, ovf}, 32'h0);
    slot(1'b0, 32'h5555, 16, 32, 1);
    slot(1'b1, 32'h6666, 16, 32, 1);
    repeat (4) @(posedge mck);
    #1;
    chk("ovf_after", {31'h0, ovf}, 32'h1);
    chk("ovf_held", {31'h0, valid}, 32'h1);
    @(posedge mck);
    #1 ready = 1'b1;
    drain("ovf");
    chk("ovf_empty", {31'h0, valid}, 32'h0);

    // 24-bck slot: word still delivered, framing error flagged at the next boundary
    reset16();
    preamble(1'b1);
    expect16(1'b0, 32'h1234); slot(1'b0, 32'h1234, 16, 32, 1);
    expect16(1'b1, 32'hBEEF); slot(1'b1, 32'hBEEF, 16, 24, 1);
    chk("short24_pending", {31'h0, ferr}, 32'h0);
    expect16(1'b0, 32'h0F0F); slot(1'b0, 32'h0F0F, 16, 32, 1);
    expect16(1'b1, 32'hF0F0); slot(1'b1, 32'hF0F0, 16, 32, 1);
    drain("short24");
    chk("short24_ferr", {31'h0, ferr}, 32'h1);

    // 10-bck slot: too few bits, nothing pushed for it
    reset16();
    preamble(1'b1);
    expect16(1'b0, 32'hCAFE); slot(1'b0, 32'hCAFE, 16, 32, 1);
    slot(1'b1, 32'hDEAD, 16, 10, 1);
    expect16(1'b0, 32'h7E57); slot(1'b0, 32'h7E57, 16, 32, 1);
    expect16(1'b1, 32'h0001); slot(1'b1, 32'h0001, 16, 32, 1);
    drain("short10");
    chk("short10_ferr", {31'h0, ferr}, 32'h1);

    // Reset mid-left-slot with two words held: everything discarded
    reset16();
    #1 ready = 1'b0;
    preamble(1'b1);
    slot(1'b0, 32'h1357, 16, 32, 1);
    slot(1'b1, 32'h2468, 16, 32, 1);
    slot(1'b0, 32'h9ABC, 16, 10, 1);
    chk("midrst_held", {31'h0, valid}, 32'h1);
    bck = 1'b0;
    @(posedge mck);
    #1 rst = 1'b1;
    @(posedge mck);
    #1;
    chk("midrst_valid", {31'h0, valid}, 32'h0);
    chk("midrst_sample", {16'h0, sample}, 32'h0);
    chk("midrst_chan", {31'h0, chan}, 32'h0);
    chk("midrst_ovf", {31'h0, ovf}, 32'h0);
    rst = 1'b0;
    ready = 1'b1;
    for (int i = 10; i < 32; i++) bit_out(1'b0, 1'b0);
    expect16(1'b1, 32'hC0DE); slot(1'b1, 32'hC0DE, 16, 32, 1);
    expect16(1'b0, 32'hFACE); slot(1'b0, 32'hFACE, 16, 32, 1);
    drain("midrst");
    chk("midrst_ferr", {31'h0, ferr}, 32'h0);

    // 24-bit instance
    bck = 1'b0;
    repeat (3) @(posedge mck);
    #1 rst = 1'b1;
    rst24 = 1'b1;
    repeat (2) @(posedge mck);
    #1 rst24 = 1'b0;
    preamble(1'b1);
    expect24(1'b0, 32'h123456); slot(1'b0, 32'h123456, 24, 32, 1);
    expect24(1'b1, 32'h800001); slot(1'b1, 32'h800001, 24, 32, 1);
    expect24(1'b0, 32'h000000); slot(1'b0, 32'h000000, 24, 32, 1);
    drain("w24");
    chk("w24_ferr", {31'h0, ferr24}, 32'h0);
    chk("w24_ovf", {31'h0, ovf24}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
